// File: rtl/ppd_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : ppd_commutator
//  Description : Serial-to-parallel input commutator for a polyphase
//                decimator. Gathers D accepted samples into a frame and
//                presents them on D parallel lanes with a one-cycle valid.
//  Revision    : 1.0  initial release
// ============================================================================
module ppd_commutator #(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_ccw               = 1
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_ena,
    input  logic                                           i_valid,
    input  logic                                           i_sync,
    input  logic [gp_idata_width-1:0]                      i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
    output logic                                           o_valid,
    output logic [$clog2(gp_decimation_factor)-1:0]        o_phase
);

    localparam int              c_w    = gp_idata_width;
    localparam int              c_d    = gp_decimation_factor;
    localparam int              c_pw   = $clog2(gp_decimation_factor);
    localparam logic [c_pw-1:0] c_last = c_pw'(gp_decimation_factor - 1);
    localparam logic [c_pw-1:0] c_one  = c_pw'(1);

    logic [c_d*c_w-1:0] r_stage;
    logic [c_d*c_w-1:0] r_data;
    logic               r_valid;
    logic [c_pw-1:0]    r_phase;

    logic [c_pw-1:0]    w_k;
    logic [c_pw-1:0]    w_lane;
    logic [c_d*c_w-1:0] w_stage_next;
    logic               w_last;

    // Sample index for this edge (sync restarts at 0), its lane, and the
    // staging contents with the incoming sample dropped into that lane.
    always_comb begin
        w_k          = i_sync ? '0 : r_phase;
        w_lane       = (gp_ccw != 0) ? (c_last - w_k) : w_k;
        w_last       = (w_k == c_last);
        w_stage_next = i_sync ? '0 : r_stage;
        for (int i = 0; i < c_d; i++) begin
            if (i == int'(w_lane)) begin
                w_stage_next[i*c_w +: c_w] = i_data;
            end
        end
    end

    // Phase/staging/output registers; a frame is published on the edge that
    // accepts its last sample, so the next frame starts with no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_phase <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_ena) begin
                if (i_valid) begin
                    r_stage <= w_stage_next;
                    if (w_last) begin
                        r_data  <= w_stage_next;
                        r_valid <= 1'b1;
                        r_phase <= '0;
                    end else begin
                        r_phase <= w_k + c_one;
                    end
                end else if (i_sync) begin
                    r_stage <= '0;
                    r_phase <= '0;
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_ppd_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppd_commutator
//  Description : Self-checking bench for ppd_commutator; drives one CCW and
//                one CW instance in parallel against a queue-based frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ppd_commutator;

    localparam int c_w = 8;
    localparam int c_d = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_ena = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_sync = 1'b0;
    logic [c_w-1:0]   i_data = '0;

    logic [c_d*c_w-1:0] o_data_ccw, o_data_cw;
    logic               o_valid_ccw, o_valid_cw;
    logic [1:0]         o_phase_ccw, o_phase_cw;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the samples of the current frame in arrival order.
    logic [c_w-1:0]     q[$];
    logic [c_d*c_w-1:0] m_ccw = '0;
    logic [c_d*c_w-1:0] m_cw  = '0;
    logic               m_valid = 1'b0;

    ppd_commutator #(.gp_idata_width(c_w), .gp_decimation_factor(c_d), .gp_ccw(1)) u_ccw (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_valid(i_valid),
        .i_sync(i_sync), .i_data(i_data),
        .o_data(o_data_ccw), .o_valid(o_valid_ccw), .o_phase(o_phase_ccw));

    ppd_commutator #(.gp_idata_width(c_w), .gp_decimation_factor(c_d), .gp_ccw(0)) u_cw (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_valid(i_valid),
        .i_sync(i_sync), .i_data(i_data),
        .o_data(o_data_cw), .o_valid(o_valid_cw), .o_phase(o_phase_cw));

    always #5 i_clk = ~i_clk;

    // Apply inputs for one clock, advance the model, return 1 time unit after the edge.
    task automatic cycle(input logic ena, input logic valid, input logic sync,
                         input logic [c_w-1:0] data);
        i_ena = ena; i_valid = valid; i_sync = sync; i_data = data;
        @(posedge i_clk);
        m_valid = 1'b0;
        if (ena) begin
            if (sync) q.delete();
            if (valid) begin
                q.push_back(data);
                if (q.size() == c_d) begin
                    for (int k = 0; k < c_d; k++) begin
                        m_ccw[(c_d-1-k)*c_w +: c_w] = q[k];
                        m_cw[k*c_w +: c_w]          = q[k];
                    end
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_ccw = '0; m_cw = '0; m_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_data_ccw !== '0 || o_valid_ccw !== 1'b0 || o_phase_ccw !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ccw: data=%h valid=%b phase=%0d, want 0/0/0", o_data_ccw, o_valid_ccw, o_phase_ccw);
        end
        n_cmp++;
        if (o_data_cw !== '0 || o_valid_cw !== 1'b0 || o_phase_cw !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cw: data=%h valid=%b phase=%0d, want 0/0/0", o_data_cw, o_valid_cw, o_phase_cw);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b0, 8'h5A);
        n_cmp++;
        if (o_valid_ccw !== 1'b0 || o_phase_ccw !== 2'd0 || o_data_ccw !== '0) begin
            n_fail++;
            $display("FAIL post_reset_disabled: valid=%b phase=%0d data=%h, want 0/0/0", o_valid_ccw, o_phase_ccw, o_data_ccw);
        end
    endtask

    task automatic test_single_frame();
        logic [c_w-1:0] s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, s[i]);
        n_cmp++;
        if (o_valid_ccw !== 1'b1 || o_data_ccw !== 32'h11223344 || o_phase_ccw !== 2'd0) begin
            n_fail++;
            $display("FAIL frame_ccw: valid=%b data=%h phase=%0d, want 1/11223344/0", o_valid_ccw, o_data_ccw, o_phase_ccw);
        end
        n_cmp++;
        if (o_valid_cw !== 1'b1 || o_data_cw !== 32'h44332211) begin
            n_fail++;
            $display("FAIL frame_cw: valid=%b data=%h, want 1/44332211", o_valid_cw, o_data_cw);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (o_valid_ccw !== 1'b0 || o_data_ccw !== 32'h11223344) begin
            n_fail++;
            $display("FAIL frame_hold: valid=%b data=%h, want 0/11223344", o_valid_ccw, o_data_ccw);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first_at = -1;
        int second_at = -1;
        logic [c_d*c_w-1:0] second_frame = '0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'(i));
            if (o_valid_ccw === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
                else begin second_at = i; second_frame = o_data_ccw; end
            end
        end
        n_cmp++;
        if (pulses != 2 || second_at - first_at != 4) begin
            n_fail++;
            $display("FAIL b2b_pulses: count=%0d spacing=%0d, want 2/4", pulses, second_at - first_at);
        end
        n_cmp++;
        if (second_frame !== 32'h05060708) begin
            n_fail++;
            $display("FAIL b2b_frame2: data=%h, want 05060708", second_frame);
        end
    endtask

    task automatic test_sync();
        logic [c_w-1:0] s [6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        int pulses = 0;
        logic [c_d*c_w-1:0] prev = o_data_ccw;
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        n_cmp++;
        if (o_phase_ccw !== 2'd0 || o_valid_ccw !== 1'b0 || o_data_ccw !== prev) begin
            n_fail++;
            $display("FAIL sync_only: phase=%0d valid=%b data=%h, want 0/0/%h", o_phase_ccw, o_valid_ccw, o_data_ccw, prev);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, (i == 2), s[i]);
            if (i == 2) begin
                n_cmp++;
                if (o_phase_ccw !== 2'd1 || o_valid_ccw !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sync_valid: phase=%0d valid=%b, want 1/0", o_phase_ccw, o_valid_ccw);
                end
            end
            if (o_valid_ccw === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || o_data_ccw !== 32'h01020304 || o_data_cw !== 32'h04030201) begin
            n_fail++;
            $display("FAIL sync_frame: pulses=%0d ccw=%h cw=%h, want 1/01020304/04030201", pulses, o_data_ccw, o_data_cw);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b1, 1'b0, 8'hC1);
        cycle(1'b1, 1'b1, 1'b0, 8'hC2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, (i == 1), 8'hEE);
            n_cmp++;
            if (o_phase_ccw !== 2'd2 || o_valid_ccw !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: phase=%0d valid=%b, want 2/0", o_phase_ccw, o_valid_ccw);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 8'hC3);
        n_cmp++;
        if (o_valid_ccw !== 1'b0 || o_phase_ccw !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_3rd: valid=%b phase=%0d, want 0/3", o_valid_ccw, o_phase_ccw);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'hC4);
        n_cmp++;
        if (o_valid_ccw !== 1'b1 || o_data_ccw !== 32'hC1C2C3C4) begin
            n_fail++;
            $display("FAIL stall_frame: valid=%b data=%h, want 1/c1c2c3c4", o_valid_ccw, o_data_ccw);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h71);
        cycle(1'b1, 1'b1, 1'b0, 8'h72);
        cycle(1'b1, 1'b1, 1'b0, 8'h73);
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (o_data_ccw !== '0 || o_valid_ccw !== 1'b0 || o_phase_ccw !== 2'd0 || o_data_cw !== '0) begin
            n_fail++;
            $display("FAIL async_reset: data=%h valid=%b phase=%0d, want 0/0/0", o_data_ccw, o_valid_ccw, o_phase_ccw);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'h81 + 8'(i));
        n_cmp++;
        if (o_valid_ccw !== 1'b1 || o_data_ccw !== 32'h81828384) begin
            n_fail++;
            $display("FAIL post_reset_frame: valid=%b data=%h, want 1/81828384", o_valid_ccw, o_data_ccw);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, 8'($urandom));
            n_cmp++;
            if (o_valid_ccw !== m_valid || o_valid_cw !== m_valid ||
                o_phase_ccw !== 2'(q.size()) || o_phase_cw !== 2'(q.size()) ||
                o_data_ccw !== m_ccw || o_data_cw !== m_cw) begin
                n_fail++;
                $display("FAIL random[%0d]: valid=%b/%b phase=%0d ccw=%h cw=%h, want valid=%b phase=%0d ccw=%h cw=%h",
                         n, o_valid_ccw, o_valid_cw, o_phase_ccw, o_data_ccw, o_data_cw,
                         m_valid, q.size(), m_ccw, m_cw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_sync();
        test_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
